count_input_ctrl: RTL and testbench

Controller that sequences the 4-digit BCD up/down counter from the two debounced push-buttons. It sits between the debouncers and the 7-segment display controller. It converts button presses into single steps, adds press-and-hold auto-repeat, clears on a two-button chord, and drives the four BCD digits the display multiplexes.

---
 rtl/count_pkg.sv | 27 ++
 rtl/count_input_ctrl_if.sv | 30 +++
 rtl/bcd_updown4.sv | 76 +++++++
 rtl/count_input_ctrl.sv | 118 +++++++++++
 tb/tb_count_input_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// +----------------------------------------------------------------------------+
// | count_pkg : shared types and constants for the BCD count input controller. |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package count_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HOLD       = 2'd1,
      REPEAT     = 2'd2,
      CLEAR_WAIT = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/count_input_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | count_input_ctrl_if : button inputs, BCD digits and pulses of the counter. |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface count_input_ctrl_if;

   logic              btn_up;
   logic              btn_dn;
   count_pkg::bcd_t   digit0;
   count_pkg::bcd_t   digit1;
   count_pkg::bcd_t   digit2;
   count_pkg::bcd_t   digit3;
   logic              step_pulse;
   logic              wrap_pulse;

   modport master (
      output btn_up, btn_dn,
      input  digit0, digit1, digit2, digit3, step_pulse, wrap_pulse
   );

   modport slave (
      input  btn_up, btn_dn,
      output digit0, digit1, digit2, digit3, step_pulse, wrap_pulse
   );

endinterface

`default_nettype wire

// File: rtl/bcd_updown4.sv
// +----------------------------------------------------------------------------+
// | bcd_updown4 : 4-digit BCD up/down register with clear and wrap flag.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_updown4
   import count_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic step_en,
   input  wire logic dir,
   input  wire logic clear,
   output bcd_t      digit0,
   output bcd_t      digit1,
   output bcd_t      digit2,
   output bcd_t      digit3,
   output logic      wrap
);

   bcd_t digits_q [4];
   bcd_t digits_d [4];
   logic carry;
   logic wrap_q;

   // Carry (up) or borrow (down) ripples from the units digit upward;
   // a carry left over past the thousands digit is a 9999<->0000 wrap.
   always_comb begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         digits_d[i] = digits_q[i];
         if (carry) begin
            if (dir == DIR_UP) begin
               if (digits_q[i] == 4'd9) begin
                  digits_d[i] = 4'd0;
               end else begin
                  digits_d[i] = digits_q[i] + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               if (digits_q[i] == 4'd0) begin
                  digits_d[i] = 4'd9;
               end else begin
                  digits_d[i] = digits_q[i] - 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= '{default: 4'd0};
         wrap_q   <= 1'b0;
      end else if (clear) begin
         digits_q <= '{default: 4'd0};
         wrap_q   <= 1'b0;
      end else if (step_en) begin
         digits_q <= digits_d;
         wrap_q   <= carry;
      end else begin
         wrap_q   <= 1'b0;
      end
   end

   assign digit0 = digits_q[0];
   assign digit1 = digits_q[1];
   assign digit2 = digits_q[2];
   assign digit3 = digits_q[3];
   assign wrap   = wrap_q;

endmodule

`default_nettype wire

// File: rtl/count_input_ctrl.sv
// +----------------------------------------------------------------------------+
// | count_input_ctrl : push-button step / auto-repeat / chord-clear sequencer. |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module count_input_ctrl
   import count_pkg::*;
#(
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   count_input_ctrl_if.slave bus
);

   localparam int TIMER_W_RAW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
   localparam int TIMER_W     = (TIMER_W_RAW < 1) ? 1 : TIMER_W_RAW;
   localparam logic [TIMER_W-1:0] HOLD_TC   = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REPEAT_TC = TIMER_W'(REPEAT_CYCLES - 1);

   state_t               state_q, state_d;
   logic                 dir_q, dir_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 up_q, dn_q;
   logic                 step_pulse_q;

   logic rise_up, rise_dn, chord, dir_btn;
   logic step_en, step_dir, clear;

   assign rise_up = bus.btn_up & ~up_q;
   assign rise_dn = bus.btn_dn & ~dn_q;
   assign chord   = bus.btn_up & bus.btn_dn;
   assign dir_btn = (dir_q == DIR_UP) ? bus.btn_up : bus.btn_dn;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      timer_d  = timer_q;
      step_en  = 1'b0;
      step_dir = dir_q;
      clear    = 1'b0;
      if (chord) begin
         clear   = 1'b1;
         timer_d = '0;
         state_d = CLEAR_WAIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_up || rise_dn) begin
                  step_en  = 1'b1;
                  step_dir = rise_up ? DIR_UP : DIR_DN;
                  dir_d    = step_dir;
                  timer_d  = '0;
                  state_d  = HOLD;
               end
            end
            HOLD, REPEAT: begin
               // Release wins over a coincident terminal count.
               if (!dir_btn) begin
                  timer_d = '0;
                  state_d = IDLE;
               end else if (timer_q == ((state_q == HOLD) ? HOLD_TC : REPEAT_TC)) begin
                  step_en = 1'b1;
                  timer_d = '0;
                  state_d = REPEAT;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            CLEAR_WAIT: begin
               if (!bus.btn_up && !bus.btn_dn) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Previous samples reset high so a button held through reset needs a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         dir_q        <= DIR_UP;
         timer_q      <= '0;
         up_q         <= 1'b1;
         dn_q         <= 1'b1;
         step_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         timer_q      <= timer_d;
         up_q         <= bus.btn_up;
         dn_q         <= bus.btn_dn;
         step_pulse_q <= step_en | clear;
      end
   end

   bcd_updown4 u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_en (step_en),
      .dir     (step_dir),
      .clear   (clear),
      .digit0  (bus.digit0),
      .digit1  (bus.digit1),
      .digit2  (bus.digit2),
      .digit3  (bus.digit3),
      .wrap    (bus.wrap_pulse)
   );

   assign bus.step_pulse = step_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_count_input_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_count_input_ctrl : directed vector bench for count_input_ctrl.          |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_count_input_ctrl;
   import count_pkg::*;

   typedef struct {
      bit          rst;
      logic        up;
      logic        dn;
      logic [15:0] digits;
      logic        sp;
      logic        wp;
      state_t      st;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;
   vec_t vecs[$];

   count_input_ctrl_if bus ();

   count_input_ctrl #(
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] digits_now();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
   endfunction

   task automatic do_reset();
      bus.btn_up = 1'b0;
      bus.btn_dn = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic void add(input bit r, input logic u, input logic d, input logic [15:0] dg,
                               input logic sp, input logic wp, input state_t st);
      vec_t v;
      v.rst = r; v.up = u; v.dn = d; v.digits = dg; v.sp = sp; v.wp = wp; v.st = st;
      vecs.push_back(v);
   endfunction

   // btn_up held from 0000: steps at edge 0, then 8, 11, 14, 17 ...
   function automatic void add_hold_up(input bit first_rst, input int n);
      int  c;
      bit  stp;
      c = 0;
      for (int k = 0; k < n; k++) begin
         stp = (k == 0) || (k >= 8 && ((k - 8) % 3) == 0);
         if (stp) c++;
         add((k == 0) ? first_rst : 1'b0, 1'b1, 1'b0, 16'(c), stp, 1'b0, (k < 8) ? HOLD : REPEAT);
      end
   endfunction

   initial begin
      n_checks   = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      bus.btn_up = 1'b0;
      bus.btn_dn = 1'b0;

      // single 2-cycle tap
      add(1, 1, 0, 16'h0001, 1, 0, HOLD);
      add(0, 1, 0, 16'h0001, 0, 0, HOLD);
      add(0, 0, 0, 16'h0001, 0, 0, IDLE);
      add(0, 0, 0, 16'h0001, 0, 0, IDLE);
      // hold for 15 edges then release
      add_hold_up(1, 15);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 16'h0004, 0, 0, IDLE);
      // wrap both ways and a borrow chain
      add(1, 0, 1, 16'h9999, 1, 1, HOLD);
      add(0, 0, 0, 16'h9999, 0, 0, IDLE);
      add(0, 1, 0, 16'h0000, 1, 1, HOLD);
      add(0, 0, 0, 16'h0000, 0, 0, IDLE);
      add(0, 0, 1, 16'h9999, 1, 1, HOLD);
      add(0, 0, 0, 16'h9999, 0, 0, IDLE);
      add(0, 0, 1, 16'h9998, 1, 0, HOLD);
      add(0, 0, 0, 16'h9998, 0, 0, IDLE);
      // hold to 0005, chord clear, staggered release, then down tap
      add_hold_up(1, 18);
      add(0, 1, 1, 16'h0000, 1, 0, CLEAR_WAIT);
      add(0, 0, 1, 16'h0000, 0, 0, CLEAR_WAIT);
      add(0, 0, 0, 16'h0000, 0, 0, IDLE);
      add(0, 0, 1, 16'h9999, 1, 1, HOLD);
      add(0, 0, 0, 16'h9999, 0, 0, IDLE);
      // release on the HOLD terminal-count edge
      add(1, 1, 0, 16'h0001, 1, 0, HOLD);
      for (int i = 0; i < 7; i++) add(0, 1, 0, 16'h0001, 0, 0, HOLD);
      add(0, 0, 0, 16'h0001, 0, 0, IDLE);
      add(0, 0, 0, 16'h0001, 0, 0, IDLE);
      add(0, 0, 0, 16'h0001, 0, 0, IDLE);

      // reset values
      tick();
      check("reset digits", digits_now(), 16'h0000);
      check("reset step_pulse", 16'(bus.step_pulse), 16'h0);
      check("reset wrap_pulse", 16'(bus.wrap_pulse), 16'h0);
      check("reset state", 16'(dut.state_q), 16'(IDLE));

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         bus.btn_up = vecs[i].up;
         bus.btn_dn = vecs[i].dn;
         tick();
         check($sformatf("vec%0d digits", i), digits_now(), vecs[i].digits);
         check($sformatf("vec%0d step_pulse", i), 16'(bus.step_pulse), 16'(vecs[i].sp));
         check($sformatf("vec%0d wrap_pulse", i), 16'(bus.wrap_pulse), 16'(vecs[i].wp));
         check($sformatf("vec%0d state", i), 16'(dut.state_q), 16'(vecs[i].st));
      end

      // button held through an asynchronous reset mid-hold
      do_reset();
      bus.btn_up = 1'b1;
      tick();
      check("pre-reset digits", digits_now(), 16'h0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset digits", digits_now(), 16'h0000);
      check("async reset state", 16'(dut.state_q), 16'(IDLE));
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("held-through-reset digits %0d", i), digits_now(), 16'h0000);
         check($sformatf("held-through-reset step %0d", i), 16'(bus.step_pulse), 16'h0);
      end
      bus.btn_up = 1'b0;
      tick();
      check("after release digits", digits_now(), 16'h0000);
      bus.btn_up = 1'b1;
      tick();
      check("re-press digits", digits_now(), 16'h0001);
      check("re-press step", 16'(bus.step_pulse), 16'h1);
      bus.btn_up = 1'b0;
      tick();
      check("re-press pulse width", 16'(bus.step_pulse), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
